bcd_convert_seq: RTL and testbench



---
 rtl/bcd_convert_seq_pkg.sv | 29 ++
 rtl/bcd_digit_adj.sv | 19 +
 rtl/bcd_convert_seq.sv | 125 ++++++++++++
 tb/tb_bcd_convert_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_convert_seq_pkg.sv
// rtl/bcd_convert_seq_pkg.sv - shared types and constants for the sequential BCD converter
package bcd_convert_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bcd_state_e;

  localparam int BCD_DIGIT_W = 4;

  // Smallest digit count n with 10^n > 2^bin_w, so every input value fits.
  function automatic int min_digits(input int bin_w);
    longint unsigned lim;
    longint unsigned p;
    int n;
    lim = 64'd1 << bin_w;
    p   = 64'd1;
    n   = 0;
    for (int i = 0; i < 20; i++) begin
      if (p <= lim) begin
        p = p * 64'd10;
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - one shift-and-add-3 digit cell (add 3 when the digit is 5..9)
module bcd_digit_adj
  import bcd_convert_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  // Codes 10..15 never occur during a conversion; forcing them to 0 keeps the cell total.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd10) begin
      digit_o = '0;
    end else if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_convert_seq.sv
// rtl/bcd_convert_seq.sv - sequential binary-to-BCD converter, one bit per clock with shared digit cells
module bcd_convert_seq
  import bcd_convert_seq_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          is_signed,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic                          sign_out,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
);

  localparam int SW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAG_ONE = BIN_W'(1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [CW-1:0]    CNT_INIT = CW'(BIN_W);

  generate
    if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
      $error("bcd_convert_seq: DIGITS too small for BIN_W");
    end
  endgenerate

  bcd_state_e      state_q, state_d;
  logic [BIN_W-1:0] mag_q, mag_d;
  logic [SW-1:0]    scratch_q, scratch_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [SW-1:0]    bcd_q, bcd_d;
  logic             sign_q, sign_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             neg_c;
  logic [SW-1:0]    scratch_adj;
  logic [SW-1:0]    scratch_shl;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign scratch_shl = {scratch_adj[SW-2:0], mag_q[BIN_W-1]};

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    bcd_d     = bcd_q;
    sign_d    = sign_q;
    neg_c     = is_signed & bin_in[BIN_W-1];

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mag_d     = neg_c ? (~bin_in + MAG_ONE) : bin_in;
          neg_d     = neg_c;
          scratch_d = '0;
          cnt_d     = CNT_INIT;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        scratch_d = scratch_shl;
        mag_d     = {mag_q[BIN_W-2:0], 1'b0};
        cnt_d     = cnt_q - CNT_ONE;
        // The final shift lands straight in the output register, saving a cycle.
        if (cnt_q == CNT_ONE) begin
          bcd_d   = scratch_shl;
          sign_d  = neg_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mag_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      bcd_q     <= '0;
      sign_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      bcd_q     <= bcd_d;
      sign_q    <= sign_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sign_out = sign_q;
  assign bcd_out  = bcd_q;

endmodule

// File: tb/tb_bcd_convert_seq.sv
// tb/tb_bcd_convert_seq.sv - scoreboard bench for bcd_convert_seq
module tb_bcd_convert_seq;

  localparam int BIN_W  = 16;
  localparam int DIGITS = 5;

  typedef struct {
    logic [19:0] bcd;
    logic        sign;
    int          c0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [15:0] bin_in = '0;
  logic        busy;
  logic        done;
  logic        sign_out;
  logic [19:0] bcd_out;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t q[$];

  logic [19:0] last_bcd = '0;
  logic        last_sign = 1'b0;
  logic        prev_done = 1'b0;

  bcd_convert_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .bin_in    (bin_in),
    .busy      (busy),
    .done      (done),
    .sign_out  (sign_out),
    .bcd_out   (bcd_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [20:0] ref_conv(input logic [15:0] b, input logic s);
    int          m;
    logic        neg;
    logic [19:0] r;
    neg = s && b[15];
    m   = neg ? (65536 - int'(b)) : int'(b);
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {neg, r};
  endfunction

  // Output-side scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_bcd  = '0;
      last_sign = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) begin
        total++;
        assert (done === 1'b0 && busy === 1'b0)
          else begin bad++; $error("FAIL done_width done=%b busy=%b exp 0/0", done, busy); end
      end
      if (done) begin
        total++;
        assert (q.size() != 0)
          else begin bad++; $error("FAIL unexpected_done got done=1 exp no pending result"); end
        if (q.size() != 0) begin
          e = q.pop_front();
          total++;
          assert (bcd_out === e.bcd)
            else begin bad++; $error("FAIL bcd got=%h exp=%h", bcd_out, e.bcd); end
          total++;
          assert (sign_out === e.sign)
            else begin bad++; $error("FAIL sign got=%b exp=%b", sign_out, e.sign); end
          total++;
          assert (cyc - e.c0 === BIN_W)
            else begin bad++; $error("FAIL latency got=%0d exp=%0d", cyc - e.c0, BIN_W); end
          total++;
          assert (busy === 1'b1)
            else begin bad++; $error("FAIL busy_in_done got=%b exp=1", busy); end
        end
        last_bcd  = bcd_out;
        last_sign = sign_out;
      end else if (busy) begin
        total++;
        assert (bcd_out === last_bcd && sign_out === last_sign)
          else begin bad++; $error("FAIL hold got=%h/%b exp=%h/%b", bcd_out, sign_out, last_bcd, last_sign); end
      end
      prev_done = done;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $error("FAIL wait_idle timeout busy=%b exp 0", busy);
    end
  endtask

  task automatic conv(input logic [15:0] b, input logic s,
                      input logic [19:0] eb, input logic es);
    exp_t e;
    wait_idle();
    bin_in = b; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    e.bcd = eb; e.sign = es; e.c0 = cyc;
    q.push_back(e);
    start = 1'b0;
    total++;
    assert (busy === 1'b1)
      else begin bad++; $error("FAIL busy_after_start got=%b exp=1", busy); end
  endtask

  task automatic conv_ref(input logic [15:0] b, input logic s);
    logic [20:0] r;
    r = ref_conv(b, s);
    conv(b, s, r[19:0], r[20]);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $error("FAIL drain timeout pending=%0d exp 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    logic [15:0] rv;
    logic [15:0] edges [9];
    edges = '{16'h0000, 16'h0001, 16'h0009, 16'h000A, 16'h0063,
              16'h7FFF, 16'h8000, 16'h8001, 16'hFFFF};

    repeat (3) @(posedge clk);
    #1;
    total++;
    assert (busy === 1'b0 && done === 1'b0)
      else begin bad++; $error("FAIL reset_ctl busy=%b done=%b exp 0/0", busy, done); end
    total++;
    assert (bcd_out === 20'h0 && sign_out === 1'b0)
      else begin bad++; $error("FAIL reset_data bcd=%h sign=%b exp 0/0", bcd_out, sign_out); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    conv(16'h0000, 1'b0, 20'h00000, 1'b0);
    conv(16'hFFFF, 1'b0, 20'h65535, 1'b0);
    conv(16'hFFFF, 1'b1, 20'h00001, 1'b1);
    conv(16'h8000, 1'b1, 20'h32768, 1'b1);
    conv(16'h0000, 1'b1, 20'h00000, 1'b0);
    drain();

    // start held high with a different value throughout the conversion
    wait_idle();
    bin_in = 16'd1234; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    e.bcd = 20'h01234; e.sign = 1'b0; e.c0 = cyc;
    q.push_back(e);
    bin_in = 16'd9999;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b0) break;
    end
    total++;
    assert (busy === 1'b0)
      else begin bad++; $error("FAIL busy_release got=%b exp=0", busy); end
    @(posedge clk); #1;
    e.bcd = 20'h09999; e.sign = 1'b0; e.c0 = cyc;
    q.push_back(e);
    start = 1'b0;
    drain();

    // reset mid-conversion
    wait_idle();
    bin_in = 16'd500; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++;
    assert (busy === 1'b0 && done === 1'b0)
      else begin bad++; $error("FAIL abort_ctl busy=%b done=%b exp 0/0", busy, done); end
    total++;
    assert (bcd_out === 20'h0 && sign_out === 1'b0)
      else begin bad++; $error("FAIL abort_data bcd=%h sign=%b exp 0/0", bcd_out, sign_out); end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    conv(16'd42, 1'b0, 20'h00042, 1'b0);
    drain();

    foreach (edges[i]) begin
      conv_ref(edges[i], 1'b0);
      conv_ref(edges[i], 1'b1);
    end
    for (int i = 0; i < 300; i++) begin
      rv = 16'($urandom);
      conv_ref(rv, 1'b0);
      conv_ref(rv, 1'b1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
